// File: rtl/eq_split.sv
// eq_split: splits one incoming audio sample into a bass-channel sample
// (arithmetic >>4, 20 bits) and a high-channel sample (arithmetic >>1, 23 bits).
// It then starts both channels together and waits for them to complete.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   in_sample    24-bit signed input sample
//   RDYin        one-cycle strobe, in_sample valid
//   RDYctrlbass  level, bass channel result ready
//   RDYctrlhigh  level, high channel result ready
//   toBass       registered sample for the bass channel
//   toHigh       registered sample for the high channel
//   RDYbass      one-cycle start strobe to the bass channel
//   RDYhigh      one-cycle start strobe to the high channel
//   busy         FSM not idle
//   overrun      sticky, a sample was dropped
//   timeout      sticky, a channel did not complete within TIMEOUT cycles
module eq_split #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] in_sample,
    input  logic        RDYin,
    input  logic        RDYctrlbass,
    input  logic        RDYctrlhigh,
    output logic [19:0] toBass,
    output logic [22:0] toHigh,
    output logic        RDYbass,
    output logic        RDYhigh,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    // Declaration values give defined power-up contents equal to the reset values.
    logic [1:0]  state_q    = StIdle;
    logic [19:0] bass_q     = '0;
    logic [22:0] high_q     = '0;
    logic [23:0] skid_q     = '0;
    logic        skid_vld_q = 1'b0;
    logic        done_b_q   = 1'b0;
    logic        done_h_q   = 1'b0;
    logic [7:0]  cnt_q      = '0;
    logic        overrun_q  = 1'b0;
    logic        timeout_q  = 1'b0;

    logic [1:0]  state_d;
    logic [19:0] bass_d;
    logic [22:0] high_d;
    logic [23:0] skid_d;
    logic        skid_vld_d;
    logic        done_b_d;
    logic        done_h_d;
    logic [7:0]  cnt_d;
    logic        overrun_d;
    logic        timeout_d;

    logic        done_b_nxt;
    logic        done_h_nxt;
    logic [7:0]  cnt_inc;

    assign done_b_nxt = done_b_q | RDYctrlbass;
    assign done_h_nxt = done_h_q | RDYctrlhigh;
    assign cnt_inc    = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        bass_d     = bass_q;
        high_d     = high_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        done_b_d   = done_b_q;
        done_h_d   = done_h_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;

        // While busy, a new sample goes to the skid entry if free, else it is lost.
        if (state_q != StIdle && RDYin) begin
            if (!skid_vld_q) begin
                skid_d     = in_sample;
                skid_vld_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (skid_vld_q) begin
                    // Sample parked on the DRAIN exit cycle; consume it now and
                    // let a simultaneous strobe take the freed entry.
                    bass_d     = skid_q[23:4];
                    high_d     = skid_q[23:1];
                    skid_d     = in_sample;
                    skid_vld_d = RDYin;
                    state_d    = StIssue;
                end else if (RDYin) begin
                    bass_d  = in_sample[23:4];
                    high_d  = in_sample[23:1];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d    = '0;
                done_b_d = 1'b0;
                done_h_d = 1'b0;
                state_d  = StWait;
            end
            StWait: begin
                if (done_b_nxt && done_h_nxt) begin
                    done_b_d = 1'b0;
                    done_h_d = 1'b0;
                    state_d  = StDrain;
                end else if (cnt_inc == TimeoutCnt) begin
                    timeout_d = 1'b1;
                    done_b_d  = 1'b0;
                    done_h_d  = 1'b0;
                    state_d   = StDrain;
                end else begin
                    cnt_d    = cnt_inc;
                    done_b_d = done_b_nxt;
                    done_h_d = done_h_nxt;
                end
            end
            StDrain: begin
                if (!RDYctrlbass && !RDYctrlhigh) begin
                    if (skid_vld_q) begin
                        bass_d     = skid_q[23:4];
                        high_d     = skid_q[23:1];
                        skid_vld_d = 1'b0;
                        state_d    = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bass_q     <= '0;
            high_q     <= '0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            done_b_q   <= 1'b0;
            done_h_q   <= 1'b0;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bass_q     <= bass_d;
            high_q     <= high_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            done_b_q   <= done_b_d;
            done_h_q   <= done_h_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign toBass  = bass_q;
    assign toHigh  = high_q;
    assign RDYbass = (state_q == StIssue);
    assign RDYhigh = (state_q == StIssue);
    assign busy    = (state_q != StIdle);
    assign overrun = overrun_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_eq_split.sv
// Directed bench for eq_split: a default-TIMEOUT instance for the data path,
// latency, skid buffer and reset checks, plus a TIMEOUT=4 instance for the
// timeout path. Both instances share the same stimulus.
module tb_eq_split;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] in_sample;
    logic        RDYin;
    logic        ctrl_b;
    logic        ctrl_h;

    logic [19:0] to_bass, to_bass_t;
    logic [22:0] to_high, to_high_t;
    logic        rdy_bass, rdy_bass_t;
    logic        rdy_high, rdy_high_t;
    logic        busy, busy_t;
    logic        overrun, overrun_t;
    logic        timeout, timeout_t;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    eq_split dut (
        .clk         (clk),
        .reset       (reset),
        .in_sample   (in_sample),
        .RDYin       (RDYin),
        .RDYctrlbass (ctrl_b),
        .RDYctrlhigh (ctrl_h),
        .toBass      (to_bass),
        .toHigh      (to_high),
        .RDYbass     (rdy_bass),
        .RDYhigh     (rdy_high),
        .busy        (busy),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    eq_split #(.TIMEOUT(4)) dut_t (
        .clk         (clk),
        .reset       (reset),
        .in_sample   (in_sample),
        .RDYin       (RDYin),
        .RDYctrlbass (ctrl_b),
        .RDYctrlhigh (ctrl_h),
        .toBass      (to_bass_t),
        .toHigh      (to_high_t),
        .RDYbass     (rdy_bass_t),
        .RDYhigh     (rdy_high_t),
        .busy        (busy_t),
        .overrun     (overrun_t),
        .timeout     (timeout_t)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Both channels report ready for one WAIT cycle, then drop: WAIT -> DRAIN -> exit.
    // Call from the ISSUE cycle.
    task automatic complete_txn();
        tick();             // WAIT
        ctrl_b = 1'b1;
        ctrl_h = 1'b1;
        tick();             // DRAIN
        ctrl_b = 1'b0;
        ctrl_h = 1'b0;
        tick();             // IDLE or ISSUE
    endtask

    initial begin
        reset     = 1'b1;
        in_sample = '0;
        RDYin     = 1'b0;
        ctrl_b    = 1'b0;
        ctrl_h    = 1'b0;

        // Power-up, then reset state
        #1;
        chk("powerup_busy", 32'(busy), 32'd0);
        chk("powerup_tobass", 32'(to_bass), 32'd0);
        tick();
        tick();
        chk("reset_tobass", 32'(to_bass), 32'd0);
        chk("reset_tohigh", 32'(to_high), 32'd0);
        chk("reset_strobes", {30'd0, rdy_bass, rdy_high}, 32'd0);
        chk("reset_flags", {29'd0, busy, overrun, timeout}, 32'd0);
        reset = 1'b0;
        tick();

        // Max positive sample, one-cycle latency and strobe
        in_sample = 24'h7FFFF0;
        RDYin     = 1'b1;
        tick();
        RDYin = 1'b0;
        chk("pos_tobass", 32'(to_bass), 32'h7FFFF);
        chk("pos_tohigh", 32'(to_high), 32'h3FFFF8);
        chk("pos_strobes", {30'd0, rdy_bass, rdy_high}, 32'd3);
        chk("pos_busy", 32'(busy), 32'd1);
        tick();
        chk("strobe_one_cycle", {30'd0, rdy_bass, rdy_high}, 32'd0);

        // Bass ready at +3, high at +7, both drop at +9: IDLE from +10
        for (int k = 1; k <= 11; k++) begin
            ctrl_b = (k >= 3 && k <= 8);
            ctrl_h = (k >= 7 && k <= 8);
            chk($sformatf("handshake_busy_k%0d", k), 32'(busy), (k <= 9) ? 32'd1 : 32'd0);
            tick();
        end
        chk("handshake_timeout", 32'(timeout), 32'd0);
        chk("handshake_hold", 32'(to_bass), 32'h7FFFF);

        // Negative sample; ready levels during ISSUE must be ignored
        in_sample = 24'hFFFFF0;
        RDYin     = 1'b1;
        tick();             // ISSUE
        RDYin = 1'b0;
        chk("neg_tobass", 32'(to_bass), 32'hFFFFF);
        chk("neg_tohigh", 32'(to_high), 32'h7FFFF8);
        ctrl_b = 1'b1;
        ctrl_h = 1'b1;
        tick();             // WAIT
        ctrl_b = 1'b0;
        ctrl_h = 1'b0;
        tick();
        tick();
        chk("ctrl_ignored_in_issue", 32'(busy), 32'd1);
        ctrl_b = 1'b1;
        ctrl_h = 1'b1;
        tick();             // DRAIN
        ctrl_b = 1'b0;
        ctrl_h = 1'b0;
        tick();
        chk("neg_idle", 32'(busy), 32'd0);

        // Three back-to-back strobes: issue, buffer, drop
        in_sample = 24'h000100;
        RDYin     = 1'b1;
        tick();             // ISSUE A
        in_sample = 24'h000200;
        tick();             // WAIT, B buffered
        in_sample = 24'h000300;
        tick();             // C dropped
        RDYin = 1'b0;
        chk("burst_overrun", 32'(overrun), 32'd1);
        chk("burst_first", 32'(to_bass), 32'h00010);
        ctrl_b = 1'b1;
        ctrl_h = 1'b1;
        tick();             // DRAIN
        ctrl_b = 1'b0;
        ctrl_h = 1'b0;
        tick();             // ISSUE B
        chk("burst_second_strobe", 32'(rdy_bass), 32'd1);
        chk("burst_second_tobass", 32'(to_bass), 32'h00020);
        chk("burst_second_tohigh", 32'(to_high), 32'h000100);
        complete_txn();
        chk("burst_third_dropped", 32'(busy), 32'd0);
        chk("burst_hold", 32'(to_bass), 32'h00020);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Strobe on the DRAIN exit cycle with an empty buffer
        in_sample = 24'h001000;
        RDYin     = 1'b1;
        tick();             // ISSUE
        RDYin = 1'b0;
        tick();             // WAIT
        ctrl_b = 1'b1;
        ctrl_h = 1'b1;
        tick();             // DRAIN
        ctrl_b    = 1'b0;
        ctrl_h    = 1'b0;
        in_sample = 24'h002000;
        RDYin     = 1'b1;
        tick();             // IDLE with parked sample
        RDYin = 1'b0;
        chk("exit_park_idle", 32'(busy), 32'd0);
        tick();             // ISSUE of parked sample
        chk("exit_park_strobe", 32'(rdy_bass), 32'd1);
        chk("exit_park_tobass", 32'(to_bass), 32'h00200);
        complete_txn();
        chk("exit_park_done", 32'(busy), 32'd0);

        // Reset in WAIT with the buffer full, strobe held during reset
        in_sample = 24'h000400;
        RDYin     = 1'b1;
        tick();             // ISSUE
        in_sample = 24'h000800;
        tick();             // WAIT, buffer full
        in_sample = 24'h000C00;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        RDYin = 1'b0;
        chk("midreset_tobass", 32'(to_bass), 32'd0);
        chk("midreset_tohigh", 32'(to_high), 32'd0);
        chk("midreset_flags", {27'd0, rdy_bass, rdy_high, busy, overrun, timeout}, 32'd0);
        tick();
        chk("midreset_buffer_empty", {30'd0, busy, rdy_bass}, 32'd0);
        in_sample = 24'h000050;
        RDYin     = 1'b1;
        tick();
        RDYin = 1'b0;
        chk("postreset_tobass", 32'(to_bass), 32'h00005);
        chk("postreset_strobe", 32'(rdy_high), 32'd1);
        complete_txn();

        // TIMEOUT=4 instance: high channel never completes
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("to_reset", 32'(timeout_t), 32'd0);
        in_sample = 24'h123450;
        RDYin     = 1'b1;
        tick();             // ISSUE
        RDYin  = 1'b0;
        ctrl_b = 1'b1;
        tick();             // first WAIT cycle
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("to_pending_w%0d", k), 32'(timeout_t), 32'd0);
            tick();
        end
        chk("to_set", 32'(timeout_t), 32'd1);
        chk("to_drain_busy", 32'(busy_t), 32'd1);
        ctrl_b = 1'b0;
        tick();
        chk("to_idle", 32'(busy_t), 32'd0);
        chk("to_sticky", 32'(timeout_t), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("to_cleared_by_reset", 32'(timeout_t), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
